// File: rtl/systolic_ctrl.sv
// Sequencer for an N x N output-stationary systolic array: clears the array,
// streams K operand beats (with stall support), lets the array settle one
// cycle, then captures and holds the result (optionally ReLU'd) until accepted.
module systolic_ctrl #(
   parameter int N    = 4,
   parameter int W    = 8,
   parameter int Accw = 32,
   parameter int KW   = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [KW-1:0]         k_len,
   input  logic                  relu_en,
   output logic                  busy,
   output logic                  done,
   output logic                  op_req,
   output logic [KW-1:0]         op_idx,
   input  logic                  op_valid,
   input  logic [N*W-1:0]        op_a,
   input  logic [N*W-1:0]        op_b,
   output logic                  arr_clr,
   output logic                  arr_en,
   output logic [N*W-1:0]        arr_a,
   output logic [N*W-1:0]        arr_b,
   input  logic [N*N*Accw-1:0]   arr_acc,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic [N*N*Accw-1:0]   res_data
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_CLEAR  = 3'd1,
      S_FEED   = 3'd2,
      S_SETTLE = 3'd3,
      S_OUT    = 3'd4
   } state_t;

   state_t                 state_q, state_d;
   logic [KW-1:0]          k_q, k_d;
   logic                   relu_q, relu_d;
   logic [KW-1:0]          idx_q, idx_d;
   logic                   done_q, done_d;
   logic [N*N*Accw-1:0]    res_q, res_d;
   logic [N*N*Accw-1:0]    cap;

   // Per-element capture value: negative accumulators (sign bit set) zeroed when ReLU latched
   for (genvar e = 0; e < N*N; e++) begin : g_relu
      assign cap[e*Accw +: Accw] = (relu_q && arr_acc[e*Accw + Accw - 1]) ?
                                   '0 : arr_acc[e*Accw +: Accw];
   end

   // Next-state and datapath register updates
   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      relu_d  = relu_q;
      idx_d   = idx_q;
      done_d  = 1'b0;
      res_d   = res_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               k_d     = k_len;
               relu_d  = relu_en;
               state_d = S_CLEAR;
            end
         end
         S_CLEAR: begin
            idx_d   = '0;
            state_d = (k_q != '0) ? S_FEED : S_SETTLE;
         end
         S_FEED: begin
            // Only accepted beats advance the index; a stall holds everything
            if (op_valid) begin
               if (idx_q == k_q - KW'(1)) begin
                  idx_d   = '0;
                  state_d = S_SETTLE;
               end else begin
                  idx_d = idx_q + KW'(1);
               end
            end
         end
         S_SETTLE: begin
            res_d   = cap;
            state_d = S_OUT;
         end
         S_OUT: begin
            if (res_ready) begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers; reset abandons any job in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         k_q     <= '0;
         relu_q  <= 1'b0;
         idx_q   <= '0;
         done_q  <= 1'b0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         relu_q  <= relu_d;
         idx_q   <= idx_d;
         done_q  <= done_d;
         res_q   <= res_d;
      end
   end

   // Outputs decoded from registered state; the operand path is a gated pass-through
   always_comb begin
      busy      = (state_q != S_IDLE);
      done      = done_q;
      op_req    = (state_q == S_FEED);
      op_idx    = idx_q;
      arr_clr   = (state_q == S_CLEAR);
      arr_en    = (state_q == S_FEED) && op_valid;
      arr_a     = arr_en ? op_a : '0;
      arr_b     = arr_en ? op_b : '0;
      res_valid = (state_q == S_OUT);
      res_data  = res_q;
   end

endmodule

// File: doc/systolic_ctrl.md
SYSTOLIC_CTRL -- requirements
Module: systolic_ctrl

Interface
REQ-001 Parameters SHALL be: N, default 4, array dimension; W, default 8, signed operand width; Accw, default 32, signed accumulator width; KW, default 16, width of the inner-dimension count.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 start  input  1  job request; sampled only in IDLE.
REQ-005 k_len  input  KW  inner dimension K; latched on an accepted start.
REQ-006 relu_en  input  1  apply ReLU to results; latched on an accepted start.
REQ-007 busy  output  1  high in every state except IDLE.
REQ-008 done  output  1  one-cycle pulse on result acceptance.
REQ-009 op_req  output  1  operand request; high throughout FEED.
REQ-010 op_idx  output  KW  current k index, 0..K-1.
REQ-011 op_valid  input  1  op_a/op_b valid for op_idx this cycle.
REQ-012 op_a  input  N*W  column k of A; lane i = A[i][k].
REQ-013 op_b  input  N*W  row k of B; lane j = B[k][j].
REQ-014 arr_clr  output  1  drives the array's synchronous clear.
REQ-015 arr_en  output  1  drives the array's accumulate enable.
REQ-016 arr_a  output  N*W  to the array's a_in.
REQ-017 arr_b  output  N*W  to the array's b_in.
REQ-018 arr_acc  input  N*N*Accw  from the array's acc_out; element (i,j) is at slice (i*N+j)*Accw.
REQ-019 res_valid  output  1  result valid.
REQ-020 res_ready  input  1  result consumer ready.
REQ-021 res_data  output  N*N*Accw  registered result, same packing as arr_acc.

Function
REQ-022 The FSM SHALL have states IDLE, CLEAR, FEED, SETTLE and OUT.
REQ-023 In IDLE, start=1 SHALL latch k_len and relu_en and go to CLEAR; start SHALL be ignored in all other states.
REQ-024 CLEAR SHALL last exactly one cycle with arr_clr=1; the next state SHALL be FEED if K>0, otherwise SETTLE.
REQ-025 In FEED, arr_en SHALL equal op_valid combinationally; arr_a/arr_b SHALL equal op_a/op_b when arr_en=1, else zero.
REQ-026 In FEED, op_idx SHALL start at 0 and increment only on cycles with op_valid=1; op_valid=0 stalls with no accumulation.
REQ-027 After the accepted beat with op_idx=K-1, the FSM SHALL go to SETTLE.
REQ-028 SETTLE SHALL last one cycle; at its end, res_data SHALL capture arr_acc elementwise, with negative elements forced to 0 when latched relu_en=1; the FSM SHALL then enter OUT.
REQ-029 In OUT, res_valid SHALL be 1 and res_data SHALL be held stable until res_valid&res_ready.
REQ-030 On handshake, the FSM SHALL pulse done for one cycle, deassert res_valid and return to IDLE in the same edge.
REQ-031 Outside CLEAR, arr_clr SHALL be 0; outside FEED, arr_en and op_req SHALL be 0 and arr_a/arr_b SHALL be 0.
REQ-032 Job latency from the start edge to the first res_valid cycle SHALL be K+2 cycles with op_valid held at 1.
REQ-033 With K=0, the result SHALL be all zeros.
REQ-034 No saturation SHALL be applied: accumulator wrap belongs to the array, and ReLU SHALL use signed comparison on Accw bits.
REQ-035 res_data SHALL retain its value after the handshake until the next SETTLE capture.

Reset
REQ-036 On rst=1, the block SHALL enter IDLE immediately regardless of clock, including mid-FEED or mid-OUT.
REQ-037 Reset values SHALL be: busy=0, done=0, op_req=0, op_idx=0, arr_clr=0, arr_en=0, res_valid=0, res_data=0, latched K=0, latched relu_en=0.
REQ-038 Any job in progress SHALL be discarded; the next job's CLEAR SHALL clear the stale array contents.

Verification
REQ-039 N=4, K=4, A=identity, B[k][j]=k*4+j, op_valid=1, relu_en=0 -> res_valid at cycle 6 after start; res_data equals B; done pulses once on res_ready.
REQ-040 K=2, A all -1, B all 3, relu_en=1 -> all 16 results 0; with relu_en=0 -> all 16 results -6.
REQ-041 K=3, op_valid low on alternating cycles -> exactly 3 arr_en beats, op_idx sequence 0,1,2, result identical to the unstalled run.
REQ-042 K=0 -> CLEAR then SETTLE, res_data all zeros, latency 2 cycles.
REQ-043 res_ready held 0 for 5 cycles in OUT, with start pulsed meanwhile -> res_data stable, start ignored, single done pulse after ready.
REQ-044 rst asserted mid-FEED at op_idx=2 -> outputs reach reset values without a clock edge; a new K=1 job then produces the correct fresh product.
